sd_spi_responder: RTL and testbench
===================================

SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the byte-address width of the backing memory port.
REQ-002 Parameter OCR, default 32'hC0FF8000, SHALL be the value returned by CMD58 (CCS=1, block addressing).
REQ-003 clk  input  1  SHALL be the single system clock for all state.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 cs  input  1  SHALL be the SPI chip select from the master, active-low, asynchronous to clk.
REQ-006 sclk  input  1  SHALL be the SPI clock from the master, mode 0, at most clk/8.
REQ-007 mosi  input  1  SHALL carry master-to-card data, MSB first.
REQ-008 miso  output  1  SHALL carry card-to-master data, MSB first.
REQ-009 mem_addr  output  ADDR_W  SHALL be the byte address {block_arg, byte_idx[8:0]}, truncated to ADDR_W.
REQ-010 mem_rdata  input  8  SHALL be the read data, valid one clk after mem_addr.
REQ-011 mem_wdata  output  8  SHALL be the write data, qualified by mem_we.
REQ-012 mem_we  output  1  SHALL be a one-clk write strobe.

Function
REQ-013 cs, sclk and mosi SHALL pass through 2-flop synchronisers; sclk edges SHALL be detected from the synchronised value.
REQ-014 Bit timing: mosi SHALL be sampled on sclk rise; miso SHALL update on sclk fall; bit 7 of each tx byte SHALL be on miso before the first rise of that byte.
REQ-015 Byte framing: a byte SHALL complete on the 8th rise after cs falls or after the previous byte; the next tx byte SHALL load at that same completion.
REQ-016 When cs is high, miso SHALL be 1, the bit counter SHALL clear, and the FSM SHALL return to CMD unless in BUSY.
REQ-017 Default tx byte SHALL be 0xFF.
REQ-018 FSM states: CMD, NCR, RESP, READ_GAP, READ_TOKEN, READ_DATA, READ_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, BUSY.
REQ-019 CMD: a rx byte with bits[7:6]=01 SHALL start a 6-byte frame (index, 32-bit arg MSB first, CRC); other bytes SHALL be ignored; CRC SHALL NOT be checked.
REQ-020 After the 6th byte, one 0xFF byte (NCR) SHALL be sent, then R1 followed by any trailing response bytes (RESP).
REQ-021 Internal idle flag SHALL be set by reset and by CMD0, and cleared by ACMD41 (CMD41 immediately after CMD55); R1 bit0 SHALL equal idle at the time R1 is sent.
REQ-022 Command responses:
- CMD0, CMD55: R1 only.
- CMD8: R1, 0x00, 0x00, 0x01, arg[7:0].
- CMD58: R1, then OCR MSB first.
- ACMD41: R1=0x00.
- CMD16: R1 only, argument ignored.
- Any other index, or CMD41 without preceding CMD55: R1 = 0x04 | idle.
REQ-023 CMD17/CMD24 while idle SHALL return R1=0x05 and perform no transfer.
REQ-024 CMD17 SHALL send:
- R1=0x00;
- one 0xFF (READ_GAP);
- token 0xFE;
- 512 bytes from mem at arg block, byte_idx 0..511;
- two CRC bytes 0xFF;
then return to CMD.
REQ-025 CMD24 SHALL send R1=0x00, then in WR_TOKEN ignore rx bytes until 0xFE.
REQ-026 WR_DATA: each of 512 rx bytes SHALL produce one mem_we pulse with mem_addr = block·512 + idx.
REQ-027 WR_CRC: two bytes SHALL be discarded.
REQ-028 WR_RESP: 0x05 SHALL be sent, then BUSY: 0x00 SHALL be sent for 8 bytes, then 0xFF, then return to CMD.
REQ-029 cs rising mid-transfer SHALL abort the transaction with no further mem_we pulses; in BUSY the remaining busy byte count SHALL be held until cs falls again.
REQ-030 byte_idx SHALL wrap to 0 only at transfer start; block addresses beyond ADDR_W SHALL truncate silently.
REQ-031 A 0xFF-prefixed poll byte during NCR or RESP SHALL NOT restart command parsing.

Reset
REQ-032 On rst=0 at a clk edge:
- miso=1, mem_we=0, mem_addr=0, mem_wdata=0;
- FSM=CMD, idle=1, counters=0, CMD55-seen flag=0.
REQ-033 Reset asserted mid-transfer SHALL take effect on that clk edge, with no further mem_we pulses.

Verification
REQ-034 CMD0 (40 00000000 95) -> 0xFF, then R1=0x01.
REQ-035 CMD8 arg 0x000001AA -> 0xFF, 01, 00, 00, 01, AA; CMD58 -> 01, C0, FF, 80, 00.
REQ-036 CMD55 then CMD41 -> R1=0x01, then 0x00; following CMD17 arg 0 with mem[i]=i -> 00, FF, FE, 00..FF, 00..FF, FF, FF.
REQ-037 CMD17 before ACMD41 -> R1=0x05, no token; CMD41 without CMD55 -> 0x05.
REQ-038 CMD24 arg 3 (ADDR_W=16), token FE, 512 bytes 0xA5, CRC -> 00, 05, eight 00s then FF; 512 mem_we pulses at addresses 0x0600..0x07FF.
REQ-039 cs raised after 100 data bytes of CMD24 -> exactly 100 mem_we pulses, miso=1, next CMD0 answered 0x01.

Source files
------------

// File: rtl/sd_spi_responder.sv
// SD card SPI-mode responder: CMD0/8/16/17/24/41/55/58 over an oversampled SPI slave,
// single-block read/write against a byte-wide memory port.
module sd_spi_responder #(
   parameter int          ADDR_W = 16,
   parameter logic [31:0] OCR    = 32'hC0FF8000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        mem_wdata,
   output logic              mem_we
);

   typedef enum logic [3:0] {
      ST_CMD, ST_NCR, ST_RESP, ST_READ_GAP, ST_READ_TOKEN, ST_READ_DATA, ST_READ_CRC,
      ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_RESP, ST_BUSY
   } state_t;

   typedef enum logic [1:0] {X_NONE, X_READ, X_WRITE} xfer_t;

   logic [1:0]  cs_s, mosi_s;
   logic [2:0]  sclk_s;
   logic        cs_q;
   logic [2:0]  bit_cnt;
   logic [6:0]  rx_sr;
   logic [7:0]  tx_sr;
   state_t      state;
   logic [2:0]  frame_cnt;
   logic [5:0]  cmd_idx;
   logic [31:0] arg;
   logic        idle, app;
   logic [31:0] resp_sr;
   logic [2:0]  resp_left;
   xfer_t       xfer;
   logic [9:0]  byte_idx;
   logic [2:0]  cnt;

   logic        cs_n, rise, fall, cs_fall, byte_done;
   logic [7:0]  rx_byte;

   assign cs_n      = cs_s[1];
   assign rise      = sclk_s[1] & ~sclk_s[2];
   assign fall      = ~sclk_s[1] & sclk_s[2];
   assign cs_fall   = cs_q & ~cs_n;
   assign byte_done = ~cs_n & rise & (bit_cnt == 3'd7);
   assign rx_byte   = {rx_sr, mosi_s[1]};

   function automatic logic [ADDR_W-1:0] blk_addr(input logic [31:0] blk, input logic [8:0] idx);
      return ADDR_W'({blk, idx});
   endfunction

   // Command decode, consumed when the NCR byte finishes and R1 is loaded.
   logic        dec_idle;
   logic [7:0]  dec_r1;
   logic [31:0] dec_trail;
   logic [2:0]  dec_len;
   xfer_t       dec_xfer;

   always_comb begin
      dec_idle  = idle;
      dec_r1    = {7'd0, idle};
      dec_trail = 32'hFFFF_FFFF;
      dec_len   = 3'd0;
      dec_xfer  = X_NONE;
      case (cmd_idx)
         6'd0: begin
            dec_idle = 1'b1;
            dec_r1   = 8'h01;
         end
         6'd8: begin
            dec_trail = {24'h000001, arg[7:0]};
            dec_len   = 3'd4;
         end
         6'd58: begin
            dec_trail = OCR;
            dec_len   = 3'd4;
         end
         6'd16, 6'd55: begin
         end
         6'd41: begin
            if (app) begin
               dec_idle = 1'b0;
               dec_r1   = 8'h00;
            end else begin
               dec_r1 = {5'd0, 1'b1, 1'b0, idle};
            end
         end
         6'd17, 6'd24: begin
            if (idle) begin
               dec_r1 = 8'h05;
            end else begin
               dec_r1   = 8'h00;
               dec_xfer = (cmd_idx == 6'd17) ? X_READ : X_WRITE;
            end
         end
         default: dec_r1 = {5'd0, 1'b1, 1'b0, idle};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cs_s      <= 2'b11;
         cs_q      <= 1'b1;
         sclk_s    <= '0;
         mosi_s    <= '0;
         miso      <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= 8'hFF;
         state     <= ST_CMD;
         frame_cnt <= '0;
         cmd_idx   <= '0;
         arg       <= '0;
         idle      <= 1'b1;
         app       <= 1'b0;
         resp_sr   <= '1;
         resp_left <= '0;
         xfer      <= X_NONE;
         byte_idx  <= '0;
         cnt       <= '0;
      end else begin
         cs_s   <= {cs_s[0], cs};
         cs_q   <= cs_s[1];
         sclk_s <= {sclk_s[1:0], sclk};
         mosi_s <= {mosi_s[0], mosi};
         mem_we <= 1'b0;
         if (cs_n) begin
            bit_cnt   <= '0;
            miso      <= 1'b1;
            frame_cnt <= '0;
            // BUSY survives a deselect so the remaining busy bytes resume on reselect.
            if (state != ST_BUSY) begin
               state <= ST_CMD;
               tx_sr <= 8'hFF;
            end
         end else begin
            if (cs_fall)
               miso <= tx_sr[7];
            else if (fall)
               miso <= tx_sr[3'd7 - bit_cnt];
            if (rise) begin
               rx_sr   <= {rx_sr[5:0], mosi_s[1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
               tx_sr <= 8'hFF;
               case (state)
                  ST_CMD: begin
                     if (frame_cnt == 3'd0) begin
                        if (rx_byte[7:6] == 2'b01) begin
                           cmd_idx   <= rx_byte[5:0];
                           frame_cnt <= 3'd1;
                        end
                     end else if (frame_cnt == 3'd5) begin
                        frame_cnt <= 3'd0;
                        state     <= ST_NCR;
                     end else begin
                        arg       <= {arg[23:0], rx_byte};
                        frame_cnt <= frame_cnt + 3'd1;
                     end
                  end
                  ST_NCR: begin
                     tx_sr     <= dec_r1;
                     idle      <= dec_idle;
                     app       <= (cmd_idx == 6'd55);
                     resp_sr   <= dec_trail;
                     resp_left <= dec_len;
                     xfer      <= dec_xfer;
                     state     <= ST_RESP;
                  end
                  ST_RESP: begin
                     if (resp_left != 3'd0) begin
                        tx_sr     <= resp_sr[31:24];
                        resp_sr   <= {resp_sr[23:0], 8'hFF};
                        resp_left <= resp_left - 3'd1;
                     end else begin
                        case (xfer)
                           X_READ: begin
                              state    <= ST_READ_GAP;
                              byte_idx <= '0;
                              mem_addr <= blk_addr(arg, 9'd0);
                           end
                           X_WRITE: state <= ST_WR_TOKEN;
                           default: state <= ST_CMD;
                        endcase
                     end
                  end
                  ST_READ_GAP: begin
                     tx_sr <= 8'hFE;
                     state <= ST_READ_TOKEN;
                  end
                  ST_READ_TOKEN: begin
                     tx_sr    <= mem_rdata;
                     byte_idx <= 10'd1;
                     mem_addr <= blk_addr(arg, 9'd1);
                     state    <= ST_READ_DATA;
                  end
                  ST_READ_DATA: begin
                     // byte_idx counts bytes already loaded; 512 means the last one just went out.
                     if (byte_idx == 10'd512) begin
                        cnt   <= '0;
                        state <= ST_READ_CRC;
                     end else begin
                        tx_sr    <= mem_rdata;
                        byte_idx <= byte_idx + 10'd1;
                        mem_addr <= blk_addr(arg, byte_idx[8:0] + 9'd1);
                     end
                  end
                  ST_READ_CRC: begin
                     if (cnt == 3'd0) cnt <= 3'd1;
                     else             state <= ST_CMD;
                  end
                  ST_WR_TOKEN: begin
                     if (rx_byte == 8'hFE) begin
                        byte_idx <= '0;
                        state    <= ST_WR_DATA;
                     end
                  end
                  ST_WR_DATA: begin
                     mem_addr  <= blk_addr(arg, byte_idx[8:0]);
                     mem_wdata <= rx_byte;
                     mem_we    <= 1'b1;
                     if (byte_idx == 10'd511) begin
                        cnt   <= '0;
                        state <= ST_WR_CRC;
                     end else begin
                        byte_idx <= byte_idx + 10'd1;
                     end
                  end
                  ST_WR_CRC: begin
                     if (cnt == 3'd0) begin
                        cnt <= 3'd1;
                     end else begin
                        tx_sr <= 8'h05;
                        state <= ST_WR_RESP;
                     end
                  end
                  ST_WR_RESP: begin
                     tx_sr <= 8'h00;
                     cnt   <= 3'd7;
                     state <= ST_BUSY;
                  end
                  ST_BUSY: begin
                     if (cnt != 3'd0) begin
                        tx_sr <= 8'h00;
                        cnt   <= cnt - 3'd1;
                     end else begin
                        state <= ST_CMD;
                     end
                  end
                  default: state <= ST_CMD;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: SPI master at clk/8, simple memory model,
// write-strobe logger, per-scenario checks against hand-computed bytes.
module tb_sd_spi_responder;
   localparam int HALF = 40;

   logic        clk = 1'b0;
   logic        rst, cs, sclk, mosi, miso, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata, mem_wdata;

   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;
   logic [15:0] we_addr_log [0:2047];
   logic [7:0]  we_data_log [0:2047];

   always #5 clk = ~clk;

   sd_spi_responder #(.ADDR_W(16), .OCR(32'hC0FF8000)) dut (
      .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we)
   );

   // Block 0 reads back mem[i] = i[7:0]; higher blocks fold in the block number.
   always @(posedge clk) begin
      mem_rdata <= mem_addr[7:0] ^ {1'b0, mem_addr[15:9]};
      if (mem_we) begin
         we_addr_log[we_cnt[10:0]] <= mem_addr;
         we_data_log[we_cnt[10:0]] <= mem_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         #HALF;
         sclk = 1'b1;
         rx[i] = miso;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic send_cmd(input logic [5:0] idx, input logic [31:0] a, input logic [7:0] crc);
      logic [7:0] r;
      spi_byte({2'b01, idx}, r);
      spi_byte(a[31:24], r);
      spi_byte(a[23:16], r);
      spi_byte(a[15:8], r);
      spi_byte(a[7:0], r);
      spi_byte(crc, r);
   endtask

   task automatic test_reset();
      rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (miso !== 1'b1)      begin n_bad++; $display("FAIL reset_miso: got %b want 1", miso); end
      n_cmp++; if (mem_we !== 1'b0)    begin n_bad++; $display("FAIL reset_we: got %b want 0", mem_we); end
      n_cmp++; if (mem_addr !== 16'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
      n_cmp++; if (mem_wdata !== 8'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 00", mem_wdata); end
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_cmd0();
      logic [7:0] e [2];
      logic [7:0] r;
      e = '{8'hFF, 8'h01};
      cs = 1'b0;
      send_cmd(6'd0, 32'h0, 8'h95);
      for (int i = 0; i < 2; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== e[i]) begin n_bad++; $display("FAIL cmd0[%0d]: got %h want %h", i, r, e[i]); end
      end
   endtask

   task automatic test_cmd8();
      logic [7:0] e [6];
      logic [7:0] r;
      e = '{8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
      send_cmd(6'd8, 32'h0000_01AA, 8'h87);
      for (int i = 0; i < 6; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== e[i]) begin n_bad++; $display("FAIL cmd8[%0d]: got %h want %h", i, r, e[i]); end
      end
   endtask

   task automatic test_cmd58(input logic [7:0] r1);
      logic [7:0] e [6];
      logic [7:0] r;
      e = '{8'hFF, r1, 8'hC0, 8'hFF, 8'h80, 8'h00};
      send_cmd(6'd58, 32'h0, 8'hFD);
      for (int i = 0; i < 6; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== e[i]) begin n_bad++; $display("FAIL cmd58[%0d]: got %h want %h", i, r, e[i]); end
      end
   endtask

   task automatic test_idle_rejects();
      logic [7:0] e [4];
      logic [7:0] r;
      e = '{8'hFF, 8'h05, 8'hFF, 8'hFF};
      send_cmd(6'd41, 32'h4000_0000, 8'h77);
      for (int i = 0; i < 2; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== e[i]) begin n_bad++; $display("FAIL cmd41_no55[%0d]: got %h want %h", i, r, e[i]); end
      end
      send_cmd(6'd17, 32'h0, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== e[i]) begin n_bad++; $display("FAIL cmd17_idle[%0d]: got %h want %h", i, r, e[i]); end
      end
   endtask

   task automatic test_acmd41();
      logic [7:0] e [4];
      logic [7:0] r;
      e = '{8'hFF, 8'h01, 8'hFF, 8'h00};
      send_cmd(6'd55, 32'h0, 8'h65);
      for (int i = 0; i < 2; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== e[i]) begin n_bad++; $display("FAIL cmd55[%0d]: got %h want %h", i, r, e[i]); end
      end
      send_cmd(6'd41, 32'h4000_0000, 8'h77);
      for (int i = 2; i < 4; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== e[i]) begin n_bad++; $display("FAIL acmd41[%0d]: got %h want %h", i, r, e[i]); end
      end
   endtask

   task automatic test_read();
      logic [7:0] e [4];
      logic [7:0] r;
      e = '{8'hFF, 8'h00, 8'hFF, 8'hFE};
      send_cmd(6'd17, 32'h0, 8'hFF);
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== e[i]) begin n_bad++; $display("FAIL read_hdr[%0d]: got %h want %h", i, r, e[i]); end
      end
      for (int i = 0; i < 512; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== 8'(i)) begin n_bad++; $display("FAIL read_data[%0d]: got %h want %h", i, r, 8'(i)); end
      end
      for (int i = 0; i < 3; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== 8'hFF) begin n_bad++; $display("FAIL read_crc[%0d]: got %h want ff", i, r); end
      end
   endtask

   task automatic test_write();
      logic [7:0] r;
      int we0, bad_rx, bad_log;
      we0 = we_cnt;
      bad_rx = 0;
      send_cmd(6'd24, 32'd3, 8'hFF);
      spi_byte(8'hFF, r);
      n_cmp++; if (r !== 8'hFF) begin n_bad++; $display("FAIL write_ncr: got %h want ff", r); end
      spi_byte(8'hFF, r);
      n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL write_r1: got %h want 00", r); end
      spi_byte(8'hFF, r); if (r !== 8'hFF) bad_rx++;
      spi_byte(8'hFE, r); if (r !== 8'hFF) bad_rx++;
      for (int i = 0; i < 512; i++) begin
         spi_byte(8'hA5, r); if (r !== 8'hFF) bad_rx++;
      end
      spi_byte(8'h12, r); if (r !== 8'hFF) bad_rx++;
      spi_byte(8'h34, r); if (r !== 8'hFF) bad_rx++;
      n_cmp++; if (bad_rx != 0) begin n_bad++; $display("FAIL write_idle_miso: got %0d non-ff bytes want 0", bad_rx); end
      spi_byte(8'hFF, r);
      n_cmp++; if (r !== 8'h05) begin n_bad++; $display("FAIL write_resp: got %h want 05", r); end
      for (int i = 0; i < 3; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL busy_a[%0d]: got %h want 00", i, r); end
      end
      // Deselect mid-busy: the remaining five busy bytes must still come out afterwards.
      cs = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++; if (miso !== 1'b1) begin n_bad++; $display("FAIL busy_desel_miso: got %b want 1", miso); end
      cs = 1'b0;
      for (int i = 0; i < 6; i++) begin
         spi_byte(8'hFF, r);
         n_cmp++;
         if (r !== ((i == 5) ? 8'hFF : 8'h00)) begin
            n_bad++; $display("FAIL busy_b[%0d]: got %h want %h", i, r, (i == 5) ? 8'hFF : 8'h00);
         end
      end
      n_cmp++; if (we_cnt - we0 != 512) begin n_bad++; $display("FAIL write_we_count: got %0d want 512", we_cnt - we0); end
      bad_log = 0;
      for (int k = 0; k < 512; k++)
         if (we_addr_log[we0 + k] !== 16'h0600 + 16'(k) || we_data_log[we0 + k] !== 8'hA5) bad_log++;
      n_cmp++; if (bad_log != 0) begin n_bad++; $display("FAIL write_we_addr_data: got %0d bad pulses want 0", bad_log); end
      n_cmp++; if (we_addr_log[we0 + 511] !== 16'h07FF) begin n_bad++; $display("FAIL write_last_addr: got %h want 07ff", we_addr_log[we0 + 511]); end
   endtask

   task automatic test_abort();
      logic [7:0] r;
      int we0, bad_log;
      we0 = we_cnt;
      send_cmd(6'd24, 32'd5, 8'hFF);
      spi_byte(8'hFF, r);
      spi_byte(8'hFF, r);
      n_cmp++; if (r !== 8'h00) begin n_bad++; $display("FAIL abort_r1: got %h want 00", r); end
      spi_byte(8'hFE, r);
      for (int i = 0; i < 100; i++) spi_byte(8'h3C, r);
      cs = 1'b1;
      repeat (40) @(negedge clk);
      n_cmp++; if (miso !== 1'b1) begin n_bad++; $display("FAIL abort_miso: got %b want 1", miso); end
      n_cmp++; if (we_cnt - we0 != 100) begin n_bad++; $display("FAIL abort_we_count: got %0d want 100", we_cnt - we0); end
      bad_log = 0;
      for (int k = 0; k < 100; k++)
         if (we_addr_log[we0 + k] !== 16'h0A00 + 16'(k) || we_data_log[we0 + k] !== 8'h3C) bad_log++;
      n_cmp++; if (bad_log != 0) begin n_bad++; $display("FAIL abort_we_addr_data: got %0d bad pulses want 0", bad_log); end
      cs = 1'b0;
      send_cmd(6'd0, 32'h0, 8'h95);
      spi_byte(8'hFF, r);
      n_cmp++; if (r !== 8'hFF) begin n_bad++; $display("FAIL abort_cmd0_ncr: got %h want ff", r); end
      spi_byte(8'hFF, r);
      n_cmp++; if (r !== 8'h01) begin n_bad++; $display("FAIL abort_cmd0_r1: got %h want 01", r); end
      n_cmp++; if (we_cnt - we0 != 100) begin n_bad++; $display("FAIL abort_no_more_we: got %0d want 100", we_cnt - we0); end
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
      @(negedge clk);
      test_reset();
      test_cmd0();
      test_cmd8();
      test_cmd58(8'h01);
      test_idle_rejects();
      test_acmd41();
      test_read();
      test_cmd58(8'h00);
      test_write();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
